ascon_pt_absorb: RTL and testbench

ASCON_PT_ABSORB -- requirements
Module: ascon_pt_absorb

---
 rtl/ascon_pt_absorb.sv | 181 ++++++++++++++++++
 tb/tb_ascon_pt_absorb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_pt_absorb.sv
// ASCON plaintext absorb stage: XORs message blocks into the rate, emits ciphertext, pads, drives p^b.
// Optional macro ASCON_PT_DECRYPT_EN adds a decrypt input (ciphertext in, plaintext out).
module ascon_pt_absorb #(
  parameter int unsigned RATE_BITS = 128,
  parameter int unsigned BW        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef ASCON_PT_DECRYPT_EN
  input  logic                 decrypt,
`endif
  input  logic [319:0]         state_in,
  input  logic [RATE_BITS-1:0] pt_data,
  input  logic                 pt_valid,
  input  logic                 pt_last,
  input  logic [BW-1:0]        pt_bytes,
  output logic                 pt_ready,
  output logic [RATE_BITS-1:0] ct_data,
  output logic [BW-1:0]        ct_bytes,
  output logic                 ct_last,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic                 perm_req,
  output logic [319:0]         perm_state,
  input  logic                 perm_ack,
  input  logic [319:0]         perm_result,
  output logic [319:0]         state_out,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned SW = 320;
  localparam int unsigned CW = SW - RATE_BITS;
  localparam int unsigned NB = RATE_BITS / 8;

  typedef enum logic [2:0] {IDLE, WAIT_PT, PERM, PAD, DONE} state_t;

  state_t                 state_q, state_nxt;
  logic [SW-1:0]          st_q, st_nxt;
  logic                   last_full_q, last_full_nxt;
  logic                   dec_q;

  logic [RATE_BITS-1:0]   ct_data_nxt;
  logic [BW-1:0]          ct_bytes_nxt;
  logic                   ct_last_nxt, ct_valid_nxt;
  logic                   perm_req_nxt;
  logic [SW-1:0]          perm_state_nxt;
  logic [SW-1:0]          state_out_nxt;
  logic                   done_nxt, busy_nxt;

  logic [BW-1:0]          n_sat, n;
  logic [RATE_BITS-1:0]   mask, pad, rate, x, ct_blk, absorbed;
  logic                   hs, idle_like;

`ifdef ASCON_PT_DECRYPT_EN
  // Direction is latched once per message.
  always_ff @(posedge clk) begin
    if (rst) dec_q <= 1'b0;
    else if (start && (state_q == IDLE || state_q == DONE)) dec_q <= decrypt;
  end
`else
  assign dec_q = 1'b0;
`endif

  assign pt_ready  = !rst && (state_q == WAIT_PT) && (!ct_valid || ct_ready);
  assign hs        = pt_valid && pt_ready;
  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign rate      = st_q[SW-1 -: RATE_BITS];

  // Byte masks: byte 0 is the most significant byte of the rate.
  always_comb begin
    n_sat = (pt_bytes > BW'(NB)) ? BW'(NB) : pt_bytes;
    n     = pt_last ? n_sat : BW'(NB);
    mask  = '0;
    pad   = '0;
    for (int i = 0; i < int'(NB); i++) begin
      mask[RATE_BITS-1-8*i -: 8] = (BW'(i) < n)  ? 8'hFF : 8'h00;
      pad[RATE_BITS-1-8*i -: 8]  = (BW'(i) == n) ? 8'h80 : 8'h00;
    end
  end

  // Pad byte is zero whenever n covers the whole rate.
  always_comb begin
    x        = pt_data & mask;
    ct_blk   = x ^ (rate & mask);
    absorbed = (dec_q ? ((rate & ~mask) | x) : (rate ^ x)) ^ pad;
  end

  always_comb begin
    state_nxt      = state_q;
    st_nxt         = st_q;
    last_full_nxt  = last_full_q;
    ct_data_nxt    = ct_data;
    ct_bytes_nxt   = ct_bytes;
    ct_last_nxt    = ct_last;
    ct_valid_nxt   = ct_valid && !ct_ready;
    perm_req_nxt   = perm_req;
    perm_state_nxt = perm_state;
    state_out_nxt  = state_out;
    done_nxt       = 1'b0;

    if (hs) begin
      ct_valid_nxt = 1'b1;
      ct_data_nxt  = ct_blk;
      ct_bytes_nxt = n;
      ct_last_nxt  = pt_last;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          st_nxt    = state_in;
          state_nxt = WAIT_PT;
        end
      end
      WAIT_PT: begin
        if (hs) begin
          st_nxt = {absorbed, st_q[CW-1:0]};
          if (pt_last && n != BW'(NB)) begin
            state_nxt     = DONE;
            state_out_nxt = st_nxt;
            done_nxt      = 1'b1;
          end else begin
            state_nxt      = PERM;
            last_full_nxt  = pt_last;
            perm_req_nxt   = 1'b1;
            perm_state_nxt = st_nxt;
          end
        end
      end
      PERM: begin
        if (perm_req && perm_ack) begin
          st_nxt       = perm_result;
          perm_req_nxt = 1'b0;
          state_nxt    = last_full_q ? PAD : WAIT_PT;
        end
      end
      PAD: begin
        st_nxt        = st_q ^ {1'b1, (SW-1)'(0)};
        state_nxt     = DONE;
        state_out_nxt = st_nxt;
        done_nxt      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == WAIT_PT) || (state_nxt == PERM) || (state_nxt == PAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      last_full_q <= 1'b0;
      ct_data     <= '0;
      ct_bytes    <= '0;
      ct_last     <= 1'b0;
      ct_valid    <= 1'b0;
      perm_req    <= 1'b0;
      perm_state  <= '0;
      state_out   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      st_q        <= st_nxt;
      last_full_q <= last_full_nxt;
      ct_data     <= ct_data_nxt;
      ct_bytes    <= ct_bytes_nxt;
      ct_last     <= ct_last_nxt;
      ct_valid    <= ct_valid_nxt;
      perm_req    <= perm_req_nxt;
      perm_state  <= perm_state_nxt;
      state_out   <= state_out_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ascon_pt_absorb.sv
// Directed bench for ascon_pt_absorb: ciphertext scoreboard plus a stand-in permutation core.
module tb_ascon_pt_absorb;

  localparam logic [319:0] B319 = {1'b1, 319'b0};
  localparam logic [127:0] BLK0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK1 = 128'h101112131415161718191A1B1C1D1E1F;

  logic         clk = 1'b0;
  logic         rst, start;
`ifdef ASCON_PT_DECRYPT_EN
  logic         decrypt;
`endif
  logic [319:0] state_in;
  logic [127:0] pt_data;
  logic         pt_valid, pt_last;
  logic [4:0]   pt_bytes;
  logic         pt_ready;
  logic [127:0] ct_data;
  logic [4:0]   ct_bytes;
  logic         ct_last, ct_valid, ct_ready;
  logic         perm_req, perm_ack;
  logic [319:0] perm_state, perm_result, state_out;
  logic         done, busy;

  ascon_pt_absorb dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ASCON_PT_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .state_in(state_in), .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last),
    .pt_bytes(pt_bytes), .pt_ready(pt_ready), .ct_data(ct_data), .ct_bytes(ct_bytes),
    .ct_last(ct_last), .ct_valid(ct_valid), .ct_ready(ct_ready), .perm_req(perm_req),
    .perm_state(perm_state), .perm_ack(perm_ack), .perm_result(perm_result),
    .state_out(state_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [4:0]   b;
    logic         l;
  } ct_t;

  ct_t sb[$];
  ct_t e;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  perm_cnt = 0;
  logic perm_prev = 1'b0;
  logic auto_ack  = 1'b1;
  int  age = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [319:0] fperm(input logic [319:0] s);
    return {s[310:0], s[319:311]} ^ {5{64'h0F1E2D3C4B5A6978}};
  endfunction

  function automatic logic [127:0] bmask(input int nb);
    logic [127:0] m;
    m = '1;
    return (nb == 0) ? 128'h0 : (m << (8 * (16 - nb)));
  endfunction

  function automatic logic [127:0] padv(input int nb);
    logic [127:0] p;
    p = 128'h80;
    return (nb >= 16) ? 128'h0 : (p << (8 * (15 - nb)));
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Ciphertext monitor and permutation-request counter
  always @(negedge clk) begin
    if (!rst && ct_valid && ct_ready) begin
      if (sb.size() == 0) chk("ct_unexpected", 320'(1), 320'(0));
      else begin
        e = sb.pop_front();
        chk("ct_data", 320'(ct_data), 320'(e.d));
        chk("ct_bytes", 320'(ct_bytes), 320'(e.b));
        chk("ct_last", 320'(ct_last), 320'(e.l));
      end
    end
    if (perm_req && !perm_prev) perm_cnt++;
    perm_prev = perm_req;
  end

  // Stand-in p^b core: acknowledges on the second cycle of a request
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_ack) begin
        perm_ack = 1'b0;
        if (perm_req) begin
          age++;
          if (age >= 2) begin
            perm_ack    = 1'b1;
            perm_result = fperm(perm_state);
            age         = 0;
          end
        end else age = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [319:0] s);
    state_in = s;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic last, input logic [4:0] nb,
                      input logic [127:0] exp_ct, input logic [4:0] exp_nb);
    ct_t t;
    bit  ok;
    t.d = exp_ct; t.b = exp_nb; t.l = last;
    sb.push_back(t);
    pt_data = d; pt_last = last; pt_bytes = nb; pt_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (pt_ready) begin ok = 1; break; end
    end
    if (!ok) chk("pt_ready_timeout", 320'(0), 320'(1));
    else tick();
    pt_valid = 1'b0; pt_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [319:0] exp);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk({tag, "_done"}, 320'(ok), 320'(1));
    if (ok) begin
      chk({tag, "_state_out"}, state_out, exp);
      chk({tag, "_busy"}, 320'(busy), 320'(0));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 320'(done), 320'(0));
      chk({tag, "_state_hold"}, state_out, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ct_valid"}, 320'(ct_valid), 320'(0));
    chk({tag, "_ct_data"}, 320'(ct_data), 320'(0));
    chk({tag, "_ct_bytes"}, 320'(ct_bytes), 320'(0));
    chk({tag, "_ct_last"}, 320'(ct_last), 320'(0));
    chk({tag, "_perm_req"}, 320'(perm_req), 320'(0));
    chk({tag, "_perm_state"}, perm_state, 320'(0));
    chk({tag, "_state_out"}, state_out, 320'(0));
    chk({tag, "_done"}, 320'(done), 320'(0));
    chk({tag, "_busy"}, 320'(busy), 320'(0));
    chk({tag, "_pt_ready"}, 320'(pt_ready), 320'(0));
  endtask

  initial begin
    logic [319:0] s0, s1, p1, fin;
    logic [127:0] d, ct0, ct1, m;
    bit found;

    rst = 1'b1; start = 1'b0; state_in = '0; pt_data = '0; pt_valid = 1'b0;
    pt_last = 1'b0; pt_bytes = '0; ct_ready = 1'b1; perm_ack = 1'b0; perm_result = '0;
`ifdef ASCON_PT_DECRYPT_EN
    decrypt = 1'b0;
`endif
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Empty last block: only padding lands in byte 0
    perm_cnt = 0;
    do_start('0);
    chk("busy_after_start", 320'(busy), 320'(1));
    send('0, 1'b1, 5'd0, '0, 5'd0);
    wait_done("empty", {8'h80, 312'h0});
    chk("empty_perm_cnt", 320'(perm_cnt), 320'(0));

    // Three-byte last block on a zero state
    perm_cnt = 0;
    do_start('0);
    send(BLK0, 1'b1, 5'd3, {24'h000102, 104'h0}, 5'd3);
    wait_done("partial3", {32'h00010280, 288'h0});
    chk("partial3_perm_cnt", 320'(perm_cnt), 320'(0));

    // Two full blocks with an output stall after the first
    perm_cnt = 0;
    s0  = rnd320();
    ct0 = BLK0 ^ s0[319:192];
    s1  = s0; s1[319:192] = s1[319:192] ^ BLK0;
    p1  = fperm(s1);
    ct1 = BLK1 ^ p1[319:192];
    fin = p1; fin[319:192] = fin[319:192] ^ BLK1;
    fin = fperm(fin) ^ B319;
    do_start(s0);
    send(BLK0, 1'b0, 5'd0, ct0, 5'd16);
    ct_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ct_valid", 320'(ct_valid), 320'(1));
      chk("stall_ct_data", 320'(ct_data), 320'(ct0));
      chk("stall_pt_ready", 320'(pt_ready), 320'(0));
    end
    tick();
    ct_ready = 1'b1;
    send(BLK1, 1'b1, 5'd16, ct1, 5'd16);
    wait_done("two_full", fin);
    chk("two_full_perm_cnt", 320'(perm_cnt), 320'(2));

    // Reset in the middle of a permutation request; late ack is ignored
    auto_ack = 1'b0;
    s0 = rnd320();
    do_start(s0);
    send(BLK1, 1'b0, 5'd0, BLK1 ^ s0[319:192], 5'd16);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (perm_req) begin found = 1; break; end
    end
    chk("abort_perm_req_seen", 320'(found), 320'(1));
    tick();
    rst = 1'b1;
    tick();
    chk_zero("abort");
    rst = 1'b0;
    perm_ack = 1'b1;
    perm_result = rnd320();
    tick();
    perm_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_perm_req", 320'(perm_req), 320'(0));
    chk("late_ack_busy", 320'(busy), 320'(0));
    chk("late_ack_state_out", state_out, 320'(0));
    chk("late_ack_pt_ready", 320'(pt_ready), 320'(0));
    auto_ack = 1'b1;
    tick();

    // Oversized pt_bytes saturates to a full last block: permute then pad
    perm_cnt = 0;
    s0 = rnd320();
    d  = {$urandom, $urandom, $urandom, $urandom};
    s1 = s0; s1[319:192] = s1[319:192] ^ d;
    do_start(s0);
    send(d, 1'b1, 5'd31, d ^ s0[319:192], 5'd16);
    wait_done("saturate", fperm(s1) ^ B319);
    chk("saturate_perm_cnt", 320'(perm_cnt), 320'(1));

    // Partial block on a random state; a second start mid-message is ignored
    perm_cnt = 0;
    s0 = rnd320();
    d  = {$urandom, $urandom, $urandom, $urandom};
    m  = bmask(5);
    fin = s0; fin[319:192] = fin[319:192] ^ (d & m) ^ padv(5);
    do_start(s0);
    state_in = ~s0; start = 1'b1;
    tick();
    start = 1'b0;
    send(d, 1'b1, 5'd5, (d ^ s0[319:192]) & m, 5'd5);
    wait_done("partial5", fin);
    chk("partial5_perm_cnt", 320'(perm_cnt), 320'(0));

`ifdef ASCON_PT_DECRYPT_EN
    // Decrypting the earlier three-byte ciphertext recovers plaintext and state
    perm_cnt = 0;
    decrypt = 1'b1;
    do_start('0);
    decrypt = 1'b0;
    send({24'h000102, 104'h0}, 1'b1, 5'd3, {24'h000102, 104'h0}, 5'd3);
    wait_done("decrypt", {32'h00010280, 288'h0});
    chk("decrypt_perm_cnt", 320'(perm_cnt), 320'(0));
`endif

    repeat (3) tick();
    chk("scoreboard_empty", 320'(sb.size()), 320'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
